// File: rtl/frame_buffer_ram_2p.sv
// Two-port row/column frame buffer with registered read pipeline, range checking and a clear engine.
// Define FRAME_BUFFER_WRITE_FORWARD_EN for write-first behaviour on same-address read/write collisions.
module frame_buffer_ram_2p #(
   parameter int                    DATA_WIDTH   = 16,
   parameter int                    ROW_SIZE     = 480,
   parameter int                    COLUMN_SIZE  = 640,
   parameter int                    ROW_WIDTH    = 9,
   parameter int                    COL_WIDTH    = 10,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iWriteEnable,
   input  logic [ROW_WIDTH-1:0]  iWriteRow,
   input  logic [COL_WIDTH-1:0]  iWriteCol,
   input  logic [DATA_WIDTH-1:0] iDataIn,
   input  logic                  iReadEnable,
   input  logic [ROW_WIDTH-1:0]  iReadRow,
   input  logic [COL_WIDTH-1:0]  iReadCol,
   output logic [DATA_WIDTH-1:0] oDataOut,
   output logic                  oDataValid,
   input  logic                  iClearStart,
   output logic                  oClearBusy,
   output logic                  oClearDone,
   output logic                  oAddrError
);

   localparam int DEPTH  = ROW_SIZE * COLUMN_SIZE;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   function automatic logic in_range(input logic [ROW_WIDTH-1:0] r,
                                     input logic [COL_WIDTH-1:0] c);
      return (int'(r) < ROW_SIZE) && (int'(c) < COLUMN_SIZE);
   endfunction

   function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_WIDTH-1:0] r,
                                                  input logic [COL_WIDTH-1:0] c);
      int t;
      t = int'(r) * COLUMN_SIZE + int'(c);
      return t[ADDR_W-1:0];
   endfunction

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [1:0]              state_q, state_d;
   logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
   logic                    aerr_q, aerr_d;
   logic [DATA_WIDTH-1:0]   rd_data_q [READ_LATENCY];
   logic [READ_LATENCY-1:0] rd_vld_q;

   logic                    wr_ok, rd_ok, ext_wr;
   logic [ADDR_W-1:0]       wr_addr, rd_addr;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   rd_word;

   assign oClearBusy = (state_q == S_CLEAR);
   assign oClearDone = (state_q == S_DONE);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (iClearStart) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The clear engine owns the single write port while busy; external writes are dropped.
   always_comb begin
      wr_ok     = in_range(iWriteRow, iWriteCol);
      wr_addr   = lin_addr(iWriteRow, iWriteCol);
      ext_wr    = iWriteEnable && !oClearBusy && wr_ok;
      mem_we    = oClearBusy || ext_wr;
      mem_waddr = oClearBusy ? clr_cnt_q : wr_addr;
      mem_wdata = oClearBusy ? CLEAR_VALUE : iDataIn;
   end

   always_ff @(posedge Clock) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      rd_ok   = in_range(iReadRow, iReadCol);
      rd_addr = lin_addr(iReadRow, iReadCol);
      rd_word = '0;
      if (rd_ok) begin
         rd_word = mem_q[rd_addr];
`ifdef FRAME_BUFFER_WRITE_FORWARD_EN
         if (mem_we && (mem_waddr == rd_addr)) rd_word = mem_wdata;
`endif
      end
      aerr_d = (iWriteEnable && !oClearBusy && !wr_ok) || (iReadEnable && !rd_ok);
   end

   // Read pipeline: stage 0 captures the RAM word, each later stage only advances on valid
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_vld_q <= '0;
         aerr_q   <= 1'b0;
         for (int k = 0; k < READ_LATENCY; k++) rd_data_q[k] <= '0;
      end else begin
         aerr_q      <= aerr_d;
         rd_vld_q[0] <= iReadEnable;
         if (iReadEnable) rd_data_q[0] <= rd_word;
         for (int k = 1; k < READ_LATENCY; k++) begin
            rd_vld_q[k] <= rd_vld_q[k-1];
            if (rd_vld_q[k-1]) rd_data_q[k] <= rd_data_q[k-1];
         end
      end
   end

   assign oDataOut   = rd_data_q[READ_LATENCY-1];
   assign oDataValid = rd_vld_q[READ_LATENCY-1];
   assign oAddrError = aerr_q;

endmodule

// File: tb/tb_frame_buffer_ram_2p.sv
// Directed bench for frame_buffer_ram_2p: 4x8 frame, read latency 2, clear value 0x00AA.
module tb_frame_buffer_ram_2p;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iWriteEnable;
   logic [2:0]  iWriteRow;
   logic [3:0]  iWriteCol;
   logic [15:0] iDataIn;
   logic        iReadEnable;
   logic [2:0]  iReadRow;
   logic [3:0]  iReadCol;
   logic [15:0] oDataOut;
   logic        oDataValid;
   logic        iClearStart;
   logic        oClearBusy;
   logic        oClearDone;
   logic        oAddrError;

   int n_vec = 0;
   int n_err = 0;

   frame_buffer_ram_2p #(
      .DATA_WIDTH(16), .ROW_SIZE(4), .COLUMN_SIZE(8), .ROW_WIDTH(3), .COL_WIDTH(4),
      .READ_LATENCY(2), .CLEAR_VALUE(16'h00AA)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .iWriteEnable(iWriteEnable), .iWriteRow(iWriteRow), .iWriteCol(iWriteCol), .iDataIn(iDataIn),
      .iReadEnable(iReadEnable), .iReadRow(iReadRow), .iReadCol(iReadCol),
      .oDataOut(oDataOut), .oDataValid(oDataValid),
      .iClearStart(iClearStart), .oClearBusy(oClearBusy), .oClearDone(oClearDone),
      .oAddrError(oAddrError)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int r, input int c, input logic [15:0] d);
      iWriteEnable = 1'b1;
      iWriteRow    = 3'(r);
      iWriteCol    = 4'(c);
      iDataIn      = d;
      tick();
      iWriteEnable = 1'b0;
   endtask

   task automatic rd(input int r, input int c, input logic [15:0] exp, input string tag);
      iReadEnable = 1'b1;
      iReadRow    = 3'(r);
      iReadCol    = 4'(c);
      tick();
      iReadEnable = 1'b0;
      tick();
      chk({tag, "_vld"}, 32'(oDataValid), 32'd1);
      chk(tag, 32'(oDataOut), 32'(exp));
   endtask

   task automatic fill(input logic [15:0] d);
      for (int a = 0; a < 32; a++) wr(a / 8, a % 8, d);
   endtask

   initial begin
      int busy_cnt, done_cnt, aerr_cnt, done_busy;
      Reset = 1'b1;
      iWriteEnable = 1'b0; iWriteRow = '0; iWriteCol = '0; iDataIn = '0;
      iReadEnable = 1'b0;  iReadRow = '0;  iReadCol = '0;  iClearStart = 1'b0;
      tick(); tick();
      chk("rst_data", 32'(oDataOut), 32'd0);
      chk("rst_vld", 32'(oDataValid), 32'd0);
      chk("rst_busy", 32'(oClearBusy), 32'd0);
      chk("rst_done", 32'(oClearDone), 32'd0);
      chk("rst_aerr", 32'(oAddrError), 32'd0);
      Reset = 1'b0;
      tick();

      // basic write then read with two-cycle latency
      wr(2, 5, 16'h1234);
      iReadEnable = 1'b1; iReadRow = 3'd2; iReadCol = 4'd5;
      tick();
      iReadEnable = 1'b0;
      chk("lat_vld_early", 32'(oDataValid), 32'd0);
      tick();
      chk("lat_vld", 32'(oDataValid), 32'd1);
      chk("lat_data", 32'(oDataOut), 32'h1234);
      tick();
      chk("lat_vld_drop", 32'(oDataValid), 32'd0);
      chk("hold_data", 32'(oDataOut), 32'h1234);

      // back-to-back reads of row 1
      for (int c = 0; c < 8; c++) wr(1, c, 16'h0100 + 16'(c));
      for (int c = 0; c < 8; c++) begin
         iReadEnable = 1'b1; iReadRow = 3'd1; iReadCol = 4'(c);
         tick();
         if (c >= 1) begin
            chk("b2b_vld", 32'(oDataValid), 32'd1);
            chk("b2b_data", 32'(oDataOut), 32'h0100 + 32'(c - 1));
         end
      end
      iReadEnable = 1'b0;
      tick();
      chk("b2b_vld_last", 32'(oDataValid), 32'd1);
      chk("b2b_data_last", 32'(oDataOut), 32'h0107);
      chk("b2b_no_aerr", 32'(oAddrError), 32'd0);
      tick();
      chk("b2b_vld_end", 32'(oDataValid), 32'd0);

      // out-of-range write and read in the same cycle
      wr(0, 0, 16'h5555);
      iWriteEnable = 1'b1; iWriteRow = 3'd4; iWriteCol = 4'd0; iDataIn = 16'hDEAD;
      iReadEnable  = 1'b1; iReadRow  = 3'd0; iReadCol  = 4'd9;
      tick();
      iWriteEnable = 1'b0; iReadEnable = 1'b0;
      chk("oob_aerr", 32'(oAddrError), 32'd1);
      tick();
      chk("oob_aerr_pulse", 32'(oAddrError), 32'd0);
      chk("oob_vld", 32'(oDataValid), 32'd1);
      chk("oob_data", 32'(oDataOut), 32'd0);
      rd(0, 0, 16'h5555, "oob_no_alias");

      // full clear with writes attempted while busy
      fill(16'hFFFF);
      iClearStart = 1'b1;
      tick();
      iClearStart = 1'b0;
      busy_cnt = 0; done_cnt = 0; aerr_cnt = 0; done_busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (oClearBusy) busy_cnt++;
         if (oClearDone) done_cnt++;
         if (oClearDone && oClearBusy) done_busy++;
         if (oAddrError) aerr_cnt++;
         iWriteEnable = (i == 20) || (i == 21);
         iWriteRow    = (i == 21) ? 3'd5 : 3'd0;
         iWriteCol    = 4'd0;
         iDataIn      = 16'h1111;
         tick();
      end
      iWriteEnable = 1'b0;
      chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
      chk("clr_done_pulses", 32'(done_cnt), 32'd1);
      chk("clr_done_busy_overlap", 32'(done_busy), 32'd0);
      chk("clr_no_aerr", 32'(aerr_cnt), 32'd0);
      for (int a = 0; a < 32; a++) rd(a / 8, a % 8, 16'h00AA, "clr_word");

      // reset in the middle of a clear
      fill(16'hFFFF);
      iClearStart = 1'b1;
      tick();
      iClearStart = 1'b0;
      repeat (10) tick();
      chk("abort_busy_pre", 32'(oClearBusy), 32'd1);
      Reset = 1'b1;
      #1;
      chk("abort_busy", 32'(oClearBusy), 32'd0);
      chk("abort_done", 32'(oClearDone), 32'd0);
      tick();
      Reset = 1'b0;
      tick();
      chk("abort_no_done", 32'(oClearDone), 32'd0);
      rd(0, 0, 16'h00AA, "abort_w0");
      rd(1, 1, 16'h00AA, "abort_w9");
      rd(1, 2, 16'hFFFF, "abort_w10");
      rd(3, 7, 16'hFFFF, "abort_w31");

      // same-address read/write collision
      wr(3, 3, 16'h0001);
      iWriteEnable = 1'b1; iWriteRow = 3'd3; iWriteCol = 4'd3; iDataIn = 16'h0002;
      iReadEnable  = 1'b1; iReadRow  = 3'd3; iReadCol  = 4'd3;
      tick();
      iWriteEnable = 1'b0; iReadEnable = 1'b0;
      tick();
      chk("coll_vld", 32'(oDataValid), 32'd1);
`ifdef FRAME_BUFFER_WRITE_FORWARD_EN
      chk("coll_data", 32'(oDataOut), 32'h0002);
`else
      chk("coll_data", 32'(oDataOut), 32'h0001);
`endif
      rd(3, 3, 16'h0002, "coll_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
